// File: rtl/videogen_pkg.sv
// =============================================================================
// videogen_pkg : shared pattern/overlay codes and colour-bar table
// Revision     : 1.0
// =============================================================================
`default_nettype none

package videogen_pkg;

   typedef enum logic [1:0] {
      PAT_GRADIENT = 2'd0,
      PAT_BARS     = 2'd1,
      PAT_GRID     = 2'd2,
      PAT_CHECKER  = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      LT_NONE         = 2'd0,
      LT_TOP_LEFT     = 2'd1,
      LT_CENTER       = 2'd2,
      LT_BOTTOM_RIGHT = 2'd3
   } lt_mode_e;

   // Returns {R,G,B} full-on flags for bar 0 (white) .. bar 7 (black).
   function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
      logic [2:0] rgb;
      case (bar)
         3'd0:    rgb = 3'b111;
         3'd1:    rgb = 3'b110;
         3'd2:    rgb = 3'b011;
         3'd3:    rgb = 3'b010;
         3'd4:    rgb = 3'b101;
         3'd5:    rgb = 3'b100;
         3'd6:    rgb = 3'b001;
         default: rgb = 3'b000;
      endcase
      return rgb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/videogen_timing.sv
// =============================================================================
// videogen_timing : raster counters, sync/DE flags, active x/y, frame strobes
// Revision        : 1.0
// =============================================================================
`default_nettype none

module videogen_timing
   import videogen_pkg::*;
#(
   parameter int CNT_W        = 12,
   parameter int H_SYNCLEN    = 62,
   parameter int H_BACKPORCH  = 60,
   parameter int H_ACTIVE     = 720,
   parameter int H_FRONTPORCH = 16,
   parameter int V_SYNCLEN    = 6,
   parameter int V_BACKPORCH  = 30,
   parameter int V_ACTIVE     = 480,
   parameter int V_FRONTPORCH = 9
) (
   input  logic             clk27_i,
   input  logic             reset_i,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic             de_o,
   output logic             hsync_act_o,
   output logic             vsync_act_o,
   output logic             h_par_o,
   output logic             v_par_o,
   output logic             origin_o,
   output logic             frame_end_o
);

   localparam int c_H_TOTAL = H_SYNCLEN + H_BACKPORCH + H_ACTIVE + H_FRONTPORCH;
   localparam int c_V_TOTAL = V_SYNCLEN + V_BACKPORCH + V_ACTIVE + V_FRONTPORCH;
   localparam int c_X_START = H_SYNCLEN + H_BACKPORCH;
   localparam int c_Y_START = V_SYNCLEN + V_BACKPORCH;

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic             w_h_last, w_v_last;

   assign w_h_last = (h_cnt_q == CNT_W'(c_H_TOTAL - 1));
   assign w_v_last = (v_cnt_q == CNT_W'(c_V_TOTAL - 1));

   always_comb begin
      h_cnt_d = w_h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (w_h_last) begin
         v_cnt_d = w_v_last ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk27_i) begin
      if (reset_i) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign hsync_act_o = (h_cnt_q < CNT_W'(H_SYNCLEN));
   assign vsync_act_o = (v_cnt_q < CNT_W'(V_SYNCLEN));
   assign de_o        = (h_cnt_q >= CNT_W'(c_X_START)) && (h_cnt_q < CNT_W'(c_X_START + H_ACTIVE)) &&
                        (v_cnt_q >= CNT_W'(c_Y_START)) && (v_cnt_q < CNT_W'(c_Y_START + V_ACTIVE));
   assign x_o         = h_cnt_q - CNT_W'(c_X_START);
   assign y_o         = v_cnt_q - CNT_W'(c_Y_START);
   assign h_par_o     = h_cnt_q[0];
   assign v_par_o     = v_cnt_q[0];
   assign origin_o    = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign frame_end_o = w_h_last && w_v_last;

endmodule

`default_nettype wire

// File: rtl/videogen_multi.sv
// =============================================================================
// videogen_multi : programmable-timing test-pattern generator, 4 patterns
//                  plus latency box overlay built when VIDEOGEN_LT_BOX_EN is set
// Revision       : 1.0
// =============================================================================
`default_nettype none

module videogen_multi
   import videogen_pkg::*;
#(
   parameter int COLOR_W       = 8,
   parameter int CNT_W         = 12,
   parameter int H_SYNCLEN     = 62,
   parameter int H_BACKPORCH   = 60,
   parameter int H_ACTIVE      = 720,
   parameter int H_FRONTPORCH  = 16,
   parameter int V_SYNCLEN     = 6,
   parameter int V_BACKPORCH   = 30,
   parameter int V_ACTIVE      = 480,
   parameter int V_FRONTPORCH  = 9,
   parameter int HSYNC_POL     = 0,
   parameter int VSYNC_POL     = 0,
   parameter int LT_WIDTH_DIV  = 4,
   parameter int LT_HEIGHT_DIV = 4
) (
   input  logic               clk27,
   input  logic               reset,
   input  logic [1:0]         pattern_sel,
   input  logic               lt_active,
   input  logic [1:0]         lt_mode,
   output logic [COLOR_W-1:0] R_out,
   output logic [COLOR_W-1:0] G_out,
   output logic [COLOR_W-1:0] B_out,
   output logic               HSYNC_out,
   output logic               VSYNC_out,
   output logic               ENABLE_out,
   output logic               frame_start
);

   localparam logic c_HPOL = 1'(HSYNC_POL);
   localparam logic c_VPOL = 1'(VSYNC_POL);

   logic [CNT_W-1:0] w_x, w_y;
   logic             w_de, w_hs_act, w_vs_act, w_h_par, w_v_par, w_origin, w_frame_end;

   videogen_timing #(
      .CNT_W        (CNT_W),
      .H_SYNCLEN    (H_SYNCLEN),
      .H_BACKPORCH  (H_BACKPORCH),
      .H_ACTIVE     (H_ACTIVE),
      .H_FRONTPORCH (H_FRONTPORCH),
      .V_SYNCLEN    (V_SYNCLEN),
      .V_BACKPORCH  (V_BACKPORCH),
      .V_ACTIVE     (V_ACTIVE),
      .V_FRONTPORCH (V_FRONTPORCH)
   ) u_timing (
      .clk27_i     (clk27),
      .reset_i     (reset),
      .x_o         (w_x),
      .y_o         (w_y),
      .de_o        (w_de),
      .hsync_act_o (w_hs_act),
      .vsync_act_o (w_vs_act),
      .h_par_o     (w_h_par),
      .v_par_o     (w_v_par),
      .origin_o    (w_origin),
      .frame_end_o (w_frame_end)
   );

   pattern_e pat_q, pat_d;
   assign pat_d = w_frame_end ? pattern_e'(pattern_sel) : pat_q;

   // Bar index = (x*8)/H_ACTIVE: count how many of the 7 bar edges x has passed.
   logic [6:0] w_bar_ge;
   logic [2:0] w_bar;

   for (genvar k = 1; k < 8; k++) begin : g_bar_thr
      localparam int c_THR = (k * H_ACTIVE + 7) / 8;
      assign w_bar_ge[k-1] = (w_x >= CNT_W'(c_THR));
   end

   always_comb begin
      w_bar = '0;
      for (int i = 0; i < 7; i++) begin
         w_bar = w_bar + {2'b00, w_bar_ge[i]};
      end
   end

   logic w_grid, w_in_box;
   assign w_grid = (w_x[3:0] == 4'd0) || (w_y[3:0] == 4'd0) ||
                   (w_x == CNT_W'(H_ACTIVE - 1)) || (w_y == CNT_W'(V_ACTIVE - 1));

`ifdef VIDEOGEN_LT_BOX_EN
   localparam int c_BOX_W = H_ACTIVE / LT_WIDTH_DIV;
   localparam int c_BOX_H = V_ACTIVE / LT_HEIGHT_DIV;
   localparam int c_CX0   = (H_ACTIVE - c_BOX_W) / 2;
   localparam int c_CY0   = (V_ACTIVE - c_BOX_H) / 2;

   always_comb begin
      w_in_box = 1'b0;
      case (lt_mode_e'(lt_mode))
         LT_TOP_LEFT:     w_in_box = (w_x < CNT_W'(c_BOX_W)) && (w_y < CNT_W'(c_BOX_H));
         LT_CENTER:       w_in_box = (w_x >= CNT_W'(c_CX0)) && (w_x < CNT_W'(c_CX0 + c_BOX_W)) &&
                                     (w_y >= CNT_W'(c_CY0)) && (w_y < CNT_W'(c_CY0 + c_BOX_H));
         LT_BOTTOM_RIGHT: w_in_box = (w_x >= CNT_W'(H_ACTIVE - c_BOX_W)) &&
                                     (w_y >= CNT_W'(V_ACTIVE - c_BOX_H));
         default:         w_in_box = 1'b0;
      endcase
   end
`else
   logic w_lt_unused;
   assign w_in_box    = 1'b0;
   assign w_lt_unused = ^{lt_active, lt_mode} ^ (LT_WIDTH_DIV > 0) ^ (LT_HEIGHT_DIV > 0);
`endif

   logic [COLOR_W-1:0] r_out_d, g_out_d, b_out_d;
   logic [2:0]         w_bar_rgb;

   always_comb begin
      w_bar_rgb = bar_rgb(w_bar);
      r_out_d   = '0;
      g_out_d   = '0;
      b_out_d   = '0;
      if (w_de) begin
         case (pat_q)
            PAT_GRADIENT: begin
               r_out_d = w_x[COLOR_W:1];
               g_out_d = w_x[COLOR_W:1];
               b_out_d = w_x[COLOR_W:1];
            end
            PAT_BARS: begin
               r_out_d = {COLOR_W{w_bar_rgb[2]}};
               g_out_d = {COLOR_W{w_bar_rgb[1]}};
               b_out_d = {COLOR_W{w_bar_rgb[0]}};
            end
            PAT_GRID: begin
               r_out_d = {COLOR_W{w_grid}};
               g_out_d = {COLOR_W{w_grid}};
               b_out_d = {COLOR_W{w_grid}};
            end
            default: begin
               r_out_d = {COLOR_W{w_h_par ^ w_v_par}};
               g_out_d = {COLOR_W{w_h_par ^ w_v_par}};
               b_out_d = {COLOR_W{w_h_par ^ w_v_par}};
            end
         endcase
`ifdef VIDEOGEN_LT_BOX_EN
         if (lt_active) begin
            r_out_d = {COLOR_W{w_in_box}};
            g_out_d = {COLOR_W{w_in_box}};
            b_out_d = {COLOR_W{w_in_box}};
         end
`endif
      end
   end

   always_ff @(posedge clk27) begin
      if (reset) begin
         pat_q       <= PAT_GRADIENT;
         R_out       <= '0;
         G_out       <= '0;
         B_out       <= '0;
         ENABLE_out  <= 1'b0;
         frame_start <= 1'b0;
         HSYNC_out   <= ~c_HPOL;
         VSYNC_out   <= ~c_VPOL;
      end else begin
         pat_q       <= pat_d;
         R_out       <= r_out_d;
         G_out       <= g_out_d;
         B_out       <= b_out_d;
         ENABLE_out  <= w_de;
         frame_start <= w_origin;
         HSYNC_out   <= w_hs_act ? c_HPOL : ~c_HPOL;
         VSYNC_out   <= w_vs_act ? c_VPOL : ~c_VPOL;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_videogen_multi.sv
// =============================================================================
// tb_videogen_multi : randomized self-checking bench for videogen_multi
// Revision          : 1.0
// =============================================================================
`default_nettype none

module tb_videogen_multi;

   localparam int HS = 4, HBP = 5, HA = 44, HFP = 3;
   localparam int VS = 2, VBP = 3, VA = 20, VFP = 2;
   localparam int HT = HS + HBP + HA + HFP;
   localparam int VT = VS + VBP + VA + VFP;
   localparam int FRAME = HT * VT;
   localparam int XS = HS + HBP;
   localparam int YS = VS + VBP;
   localparam bit HPOL = 1'b1;
   localparam bit VPOL = 1'b0;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
   } vid_t;

   logic       clk27 = 1'b0;
   logic       reset;
   logic [1:0] pattern_sel;
   logic       lt_active;
   logic [1:0] lt_mode;
   logic [7:0] R_out, G_out, B_out;
   logic       HSYNC_out, VSYNC_out, ENABLE_out, frame_start;

   always #5 clk27 = ~clk27;

   videogen_multi #(
      .COLOR_W(8), .CNT_W(12),
      .H_SYNCLEN(HS), .H_BACKPORCH(HBP), .H_ACTIVE(HA), .H_FRONTPORCH(HFP),
      .V_SYNCLEN(VS), .V_BACKPORCH(VBP), .V_ACTIVE(VA), .V_FRONTPORCH(VFP),
      .HSYNC_POL(1), .VSYNC_POL(0), .LT_WIDTH_DIV(4), .LT_HEIGHT_DIV(4)
   ) dut (
      .clk27(clk27), .reset(reset), .pattern_sel(pattern_sel),
      .lt_active(lt_active), .lt_mode(lt_mode),
      .R_out(R_out), .G_out(G_out), .B_out(B_out),
      .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out),
      .ENABLE_out(ENABLE_out), .frame_start(frame_start)
   );

   int checks = 0;
   int errors = 0;
   int n;         // raster position index within the frame (h + v*HT)
   int mpat;      // pattern in force for the current frame
   int npat;      // pattern captured at the end of the current frame
   int cyc = 0;
   int last_fs;
   int de_cnt;
   int hs_cnt;

   // Expected outputs for the raster position n, from the plain pixel rules.
   function automatic vid_t model(input int pos, input int pat, input logic lta, input logic [1:0] ltm);
      vid_t o;
      int   h, v, x, y, bar, lvl;
      bit   act;
      h   = pos % HT;
      v   = pos / HT;
      x   = h - XS;
      y   = v - YS;
      act = (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
      o    = '0;
      o.hs = (h < HS) ? HPOL : ~HPOL;
      o.vs = (v < VS) ? VPOL : ~VPOL;
      o.de = act;
      o.fs = (pos == 0);
      if (act) begin
         lvl = 0;
         case (pat)
            0: begin
               lvl = (x / 2) % 256;
               o.r = 8'(lvl); o.g = 8'(lvl); o.b = 8'(lvl);
            end
            1: begin
               bar = (x * 8) / HA;
               o.r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
               o.g = (bar == 0 || bar == 1 || bar == 2 || bar == 3) ? 8'hFF : 8'h00;
               o.b = (bar == 0 || bar == 2 || bar == 4 || bar == 6) ? 8'hFF : 8'h00;
            end
            2: begin
               lvl = ((x % 16) == 0 || (y % 16) == 0 || x == HA - 1 || y == VA - 1) ? 255 : 0;
               o.r = 8'(lvl); o.g = 8'(lvl); o.b = 8'(lvl);
            end
            default: begin
               lvl = (((h % 2) ^ (v % 2)) != 0) ? 255 : 0;
               o.r = 8'(lvl); o.g = 8'(lvl); o.b = 8'(lvl);
            end
         endcase
`ifdef VIDEOGEN_LT_BOX_EN
         if (lta) begin
            bit inb;
            inb = 1'b0;
            case (ltm)
               2'd1: inb = (x < HA / 4) && (y < VA / 4);
               2'd2: inb = (x >= (HA - HA / 4) / 2) && (x < (HA - HA / 4) / 2 + HA / 4) &&
                           (y >= (VA - VA / 4) / 2) && (y < (VA - VA / 4) / 2 + VA / 4);
               2'd3: inb = (x >= HA - HA / 4) && (y >= VA - VA / 4);
               default: inb = 1'b0;
            endcase
            o.r = inb ? 8'hFF : 8'h00; o.g = o.r; o.b = o.r;
         end
`endif
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic reset_cycle();
      reset       = 1'b1;
      pattern_sel = 2'($urandom_range(0, 3));
      @(posedge clk27);
      #1;
      cyc++;
      check("rst_rgb", {8'h0, R_out, G_out, B_out}, 32'h0);
      check("rst_de_fs", {30'h0, ENABLE_out, frame_start}, 32'h0);
      check("rst_sync", {30'h0, HSYNC_out, VSYNC_out}, {30'h0, ~HPOL, ~VPOL});
   endtask

   task automatic restart_model();
      reset   = 1'b0;
      n       = 0;
      mpat    = 0;
      npat    = 0;
      last_fs = -1;
      de_cnt  = 0;
      hs_cnt  = 0;
   endtask

   task automatic tick(input bit rnd);
      vid_t e;
      e = model(n, mpat, lt_active, lt_mode);
      if (n == FRAME - 1) npat = int'(pattern_sel);
      @(posedge clk27);
      #1;
      cyc++;
      check("rgb", {8'h0, R_out, G_out, B_out}, {8'h0, e.r, e.g, e.b});
      check("sync", {30'h0, HSYNC_out, VSYNC_out}, {30'h0, e.hs, e.vs});
      check("de", {31'h0, ENABLE_out}, {31'h0, e.de});
      check("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
      if (frame_start) begin
         if (last_fs >= 0) begin
            check("fs_period", cyc - last_fs, FRAME);
            check("de_per_frame", de_cnt, HA * VA);
            check("hs_per_frame", hs_cnt, HS * VT);
         end
         last_fs = cyc;
         de_cnt  = 0;
         hs_cnt  = 0;
      end
      de_cnt += int'(ENABLE_out);
      hs_cnt += (HSYNC_out == HPOL) ? 1 : 0;
      n++;
      if (n == FRAME) begin
         n    = 0;
         mpat = npat;
      end
      if (rnd) begin
         pattern_sel = 2'($urandom_range(0, 3));
         lt_active   = 1'($urandom_range(0, 1));
         lt_mode     = 2'($urandom_range(0, 3));
      end
   endtask

   initial begin
      reset       = 1'b1;
      pattern_sel = 2'd0;
      lt_active   = 1'b0;
      lt_mode     = 2'd0;

      for (int i = 0; i < 10; i++) reset_cycle();
      restart_model();

      // Random pattern requests and overlay settings for two frames.
      for (int i = 0; i < 2 * FRAME; i++) tick(1'b1);

      // Colour bars held steady, no overlay, for two full frames.
      pattern_sel = 2'd1;
      lt_active   = 1'b0;
      lt_mode     = 2'd0;
      for (int i = 0; i < 2 * FRAME; i++) tick(1'b0);

      // Change to grid mid-frame: current frame keeps bars, grid from next frame.
      while (n != 200 * 0 + 10 * HT) tick(1'b0);
      pattern_sel = 2'd2;
      for (int i = 0; i < FRAME + HT; i++) tick(1'b0);

      // Reset mid-line, then restart from the origin.
      while (n != 12 * HT + 30) tick(1'b1);
      for (int i = 0; i < 3; i++) reset_cycle();
      restart_model();
      lt_active = 1'b0;
      for (int i = 0; i < 2 * FRAME + 5; i++) tick(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
